ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst  in  1 each  ID/EX control fields.
REQ-004 ALUOp  in  4  operation select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1001 SLL, 1010 SRL, 1000 MUL; any other code yields result 0.
REQ-005 PCplus4, ReadData1, ReadData2, SignExtendResult  in  32 each  ID/EX data fields.
REQ-006 rs, rt, rd  in  5 each  ID/EX register addresses.
REQ-007 memwb_RegWrite  in  1; memwb_rd  in  5; memwb_data  in  32  MEM/WB writeback bus, used for forwarding.
REQ-008 flush  in  1  kill the instruction in EX.
REQ-009 stall  out  1  upstream (IF, IF/ID, ID/EX) holds while high.
REQ-010 exmem_RegWrite, exmem_MemtoReg, exmem_MemWrite, exmem_MemRead  out  1 each  registered control.
REQ-011 exmem_ALUResult, exmem_WriteData, exmem_BranchTarget  out  32 each; exmem_WriteReg  out  5; exmem_Zero  out  1; all registered.

Function
REQ-012 Forward A: exmem_RegWrite && exmem_WriteReg!=0 && exmem_WriteReg==rs selects exmem_ALUResult; else memwb_RegWrite && memwb_rd!=0 && memwb_rd==rs selects memwb_data; else ReadData1. EX/MEM wins when both match.
REQ-013 Forward B: same rule on rt, giving fwdB; exmem_WriteData is loaded with fwdB.
REQ-014 ALU operand B is SignExtendResult when ALUSrc=1, else fwdB.
REQ-015 Shifts: amount = SignExtendResult[10:6]; shifted value is operand B.
REQ-016 ADD/SUB wrap modulo 2^32; no overflow output. SLT result is 1 or 0.
REQ-017 Write register is rd when RegDst=1, else rt. Zero = (ALU result == 0). Branch target = PCplus4 + (SignExtendResult << 2), mod 2^32.
REQ-018 Non-MUL ops are single-cycle: inputs at edge N appear on exmem_* after edge N+1; stall stays 0.
REQ-019 MUL FSM has three states: IDLE, BUSY, DONE.
REQ-020 IDLE with ALUOp=MUL and flush=0: stall=1 combinationally; forwarded operand A and operand B latched; counter cleared; next state BUSY; EX/MEM loads a bubble.
REQ-021 BUSY: one shift-add step per cycle, 32 cycles (count 0..31); stall=1; EX/MEM loads a bubble each cycle; count 31 -> DONE.
REQ-022 DONE: stall=0; EX/MEM loads the low 32 bits of the product plus the current control fields; next state IDLE. Stall is high for 33 consecutive cycles per MUL.
REQ-023 Bubble: all four exmem control bits are 0; data outputs don't-care.
REQ-024 flush=1: EX/MEM loads a bubble at that edge. In BUSY or DONE, FSM returns to IDLE and stall drops next cycle. flush beats MUL start.
REQ-025 A MUL following a MUL may only start from IDLE; the FSM never re-enters BUSY directly from DONE.

Reset
REQ-026 rst=1 at posedge: FSM=IDLE, counter=0, all exmem_* outputs=0, stall=0 from the next cycle; any multiply in progress is abandoned.
REQ-027 rst takes priority over flush and over MUL start.

Verification
REQ-028 ADD with ReadData1=5, ReadData2=7, ALUSrc=0, RegDst=1, rd=3 -> one edge later exmem_ALUResult=12, exmem_WriteReg=3, exmem_Zero=0, stall=0.
REQ-029 Back-to-back: ADD r2=r0+imm 9, then SUB rd=4 using rs=2, ReadData1 stale 0, ReadData2=4 -> SUB result=5 via EX/MEM forward. Also cover EX/MEM and MEM/WB matching same rs -> EX/MEM value selected. Also cover rd=0 -> never forwarded.
REQ-030 MUL with A=0xFFFFFFFF, B=3 -> stall high exactly 33 cycles; exmem_ALUResult=0xFFFFFFFD after the DONE edge; 33 bubbles precede it.
REQ-031 flush asserted at BUSY count 10 -> stall low next cycle; FSM IDLE; no product ever written; exmem_RegWrite=0.
REQ-032 rst asserted mid-MUL -> all outputs 0 and stall 0 next cycle. A subsequent ADD then completes in one cycle.
REQ-033 Branch: PCplus4=0x100, SignExtendResult=0xFFFFFFFF -> exmem_BranchTarget=0x0FC. Also SLT -1 vs 1 -> 1. Also SRL 0x80000000 by 31 -> 1.

Source files
------------

// File: rtl/ex_if.sv
`default_nettype none
// ============================================================================
// Module : ex_if
// Bundles the ID/EX fields, MEM/WB forwarding bus, flush/stall and EX/MEM outputs.
// Rev    : 1.0
// ============================================================================
interface ex_if;
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemWrite;
    logic        MemRead;
    logic        ALUSrc;
    logic        RegDst;
    logic [3:0]  ALUOp;
    logic [31:0] PCplus4;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] SignExtendResult;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        flush;
    logic        stall;
    logic        exmem_RegWrite;
    logic        exmem_MemtoReg;
    logic        exmem_MemWrite;
    logic        exmem_MemRead;
    logic [31:0] exmem_ALUResult;
    logic [31:0] exmem_WriteData;
    logic [31:0] exmem_BranchTarget;
    logic [4:0]  exmem_WriteReg;
    logic        exmem_Zero;

    modport master (
        output RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp,
        output PCplus4, ReadData1, ReadData2, SignExtendResult, rs, rt, rd,
        output memwb_RegWrite, memwb_rd, memwb_data, flush,
        input  stall, exmem_RegWrite, exmem_MemtoReg, exmem_MemWrite, exmem_MemRead,
        input  exmem_ALUResult, exmem_WriteData, exmem_BranchTarget, exmem_WriteReg, exmem_Zero
    );

    modport slave (
        input  RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp,
        input  PCplus4, ReadData1, ReadData2, SignExtendResult, rs, rt, rd,
        input  memwb_RegWrite, memwb_rd, memwb_data, flush,
        output stall, exmem_RegWrite, exmem_MemtoReg, exmem_MemWrite, exmem_MemRead,
        output exmem_ALUResult, exmem_WriteData, exmem_BranchTarget, exmem_WriteReg, exmem_Zero
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Execute stage: operand forwarding, ALU, 32-step shift-add multiplier, EX/MEM register.
// Rev    : 1.0
// ============================================================================
module ex_stage (
    input wire   clk,
    input wire   rst,
    ex_if.slave  bus
);
    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_BUSY = 2'd1,
        c_ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_SLL = 4'b1001;
    localparam logic [3:0] c_OP_SRL = 4'b1010;
    localparam logic [3:0] c_OP_MUL = 4'b1000;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_acc;
    logic        r_rw;
    logic        r_mtr;
    logic        r_mw;
    logic        r_mr;
    logic        r_zero;
    logic [31:0] r_res;
    logic [31:0] r_wd;
    logic [31:0] r_bt;
    logic [4:0]  r_wr;

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [31:0] w_bt;
    logic [31:0] w_acc_next;
    logic [4:0]  w_shamt;
    logic [4:0]  w_wr;
    logic        w_mul_start;

    // EX/MEM result has priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = bus.ReadData1;
        if (r_rw && (r_wr != 5'd0) && (r_wr == bus.rs))
            w_fwd_a = r_res;
        else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.rs))
            w_fwd_a = bus.memwb_data;
    end

    always_comb begin
        w_fwd_b = bus.ReadData2;
        if (r_rw && (r_wr != 5'd0) && (r_wr == bus.rt))
            w_fwd_b = r_res;
        else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.rt))
            w_fwd_b = bus.memwb_data;
    end

    assign w_op_b     = bus.ALUSrc ? bus.SignExtendResult : w_fwd_b;
    assign w_shamt    = bus.SignExtendResult[10:6];
    assign w_wr       = bus.RegDst ? bus.rd : bus.rt;
    assign w_bt       = bus.PCplus4 + {bus.SignExtendResult[29:0], 2'b00};
    assign w_acc_next = r_mul_b[0] ? (r_acc + r_mul_a) : r_acc;

    always_comb begin
        w_alu = 32'd0;
        case (bus.ALUOp)
            c_OP_AND: w_alu = w_fwd_a & w_op_b;
            c_OP_OR:  w_alu = w_fwd_a | w_op_b;
            c_OP_ADD: w_alu = w_fwd_a + w_op_b;
            c_OP_SUB: w_alu = w_fwd_a - w_op_b;
            c_OP_SLT: w_alu = {31'd0, ($signed(w_fwd_a) < $signed(w_op_b))};
            c_OP_NOR: w_alu = ~(w_fwd_a | w_op_b);
            c_OP_SLL: w_alu = w_op_b << w_shamt;
            c_OP_SRL: w_alu = w_op_b >> w_shamt;
            default:  w_alu = 32'd0;
        endcase
    end

    assign w_mul_start = (r_state == c_ST_IDLE) && (bus.ALUOp == c_OP_MUL) && !bus.flush;
    assign bus.stall   = !rst && (w_mul_start || (r_state == c_ST_BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_count <= 5'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_acc   <= 32'd0;
            r_rw    <= 1'b0;
            r_mtr   <= 1'b0;
            r_mw    <= 1'b0;
            r_mr    <= 1'b0;
            r_zero  <= 1'b0;
            r_res   <= 32'd0;
            r_wd    <= 32'd0;
            r_bt    <= 32'd0;
            r_wr    <= 5'd0;
        end else begin
            // Data fields always follow the current instruction; bubbles only clear control.
            r_res  <= w_alu;
            r_zero <= (w_alu == 32'd0);
            r_wd   <= w_fwd_b;
            r_bt   <= w_bt;
            r_wr   <= w_wr;
            r_rw   <= bus.RegWrite;
            r_mtr  <= bus.MemtoReg;
            r_mw   <= bus.MemWrite;
            r_mr   <= bus.MemRead;
            if (bus.flush) begin
                r_rw    <= 1'b0;
                r_mtr   <= 1'b0;
                r_mw    <= 1'b0;
                r_mr    <= 1'b0;
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (bus.ALUOp == c_OP_MUL) begin
                            r_mul_a <= w_fwd_a;
                            r_mul_b <= w_op_b;
                            r_acc   <= 32'd0;
                            r_count <= 5'd0;
                            r_state <= c_ST_BUSY;
                            r_rw    <= 1'b0;
                            r_mtr   <= 1'b0;
                            r_mw    <= 1'b0;
                            r_mr    <= 1'b0;
                        end
                    end
                    c_ST_BUSY: begin
                        r_acc   <= w_acc_next;
                        r_mul_a <= {r_mul_a[30:0], 1'b0};
                        r_mul_b <= {1'b0, r_mul_b[31:1]};
                        r_count <= r_count + 5'd1;
                        r_rw    <= 1'b0;
                        r_mtr   <= 1'b0;
                        r_mw    <= 1'b0;
                        r_mr    <= 1'b0;
                        if (r_count == 5'd31)
                            r_state <= c_ST_DONE;
                    end
                    c_ST_DONE: begin
                        r_res   <= r_acc;
                        r_zero  <= (r_acc == 32'd0);
                        r_state <= c_ST_IDLE;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign bus.exmem_RegWrite     = r_rw;
    assign bus.exmem_MemtoReg     = r_mtr;
    assign bus.exmem_MemWrite     = r_mw;
    assign bus.exmem_MemRead      = r_mr;
    assign bus.exmem_ALUResult    = r_res;
    assign bus.exmem_WriteData    = r_wd;
    assign bus.exmem_BranchTarget = r_bt;
    assign bus.exmem_WriteReg     = r_wr;
    assign bus.exmem_Zero         = r_zero;
endmodule
`default_nettype wire
